unit_cmd_sequencer: RTL and testbench
=====================================

# unit_cmd_sequencer

Upstream control stage for the compute unit: accepts queued operation descriptors (opmode, source base, destination base, length) and sweeps the three operand BRAM read addresses. It drives the unit's `in_valid`/`opmode` aligned to the BRAM read latency and writes each result vector back to the result BRAM at consecutive addresses. It replaces hard-wired address sweeps with a command-driven sequence and guarantees that opmode never changes while results of a previous command are still in flight.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries, power of two, ≥2.
- `RD_LAT`, 1: BRAM read latency in cycles (1 or 2).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_opmode` in 8: opmode for the whole command.
- `cmd_src` in 10: operand base address, shared by BRAM1/2/3.
- `cmd_dst` in 10: result base address in BRAM4.
- `cmd_len` in 10: vector count; 0 encodes 1024.
- `rd_addr` out 10: address to BRAM1/2/3.
- `unit_in_valid` out 1: operand data on BRAM outputs is valid this cycle.
- `unit_opmode` out 8: opmode to the unit.
- `unit_out` in 256: unit result.
- `unit_out_valid` in 1: result valid.
- `wr_addr` out 10: BRAM4 address.
- `wr_data` out 288: `{32'b0, unit_out}`.
- `wr_we` out 36: all-ones on a write cycle, else zero.
- `busy` out 1: FSM not IDLE, or FIFO non-empty.
- `done` out 1: one-cycle pulse per completed command.
- `err` out 1: sticky; set on a stray result.

## Operation
- Command FIFO:
  - Push on `cmd_valid & cmd_ready`. `cmd_ready = !full`; there is no full-bypass.
  - Pop only in IDLE. A push and pop in the same cycle are both honoured.
- FSM states IDLE, ISSUE, DRAIN:
  - IDLE → ISSUE when the FIFO is non-empty. The transition pops the head and latches opmode/src/dst/len. Set `issue_cnt = 0` and `ret_cnt = 0`.
  - ISSUE: `rd_addr = src + issue_cnt` (mod 1024), and `issue_cnt` increments every cycle. After the `len`-th address, go to DRAIN.
  - DRAIN → IDLE in the cycle `ret_cnt == len`. `done` pulses on that transition.
- Read-valid pipeline: `RD_LAT`-stage shift of the "address issued" flag, which drives `unit_in_valid`.
- `unit_opmode` is a register loaded only on the IDLE→ISSUE transition. Because all results have returned by then, no in-flight vector sees an opmode change.
- Writeback:
  - On `unit_out_valid` in ISSUE or DRAIN, register `wr_addr = dst + ret_cnt` (mod 1024), `wr_data`, and `wr_we = '1`, then increment `ret_cnt`.
  - Otherwise `wr_we = 0`, and `wr_addr`/`wr_data` hold their values.
- Stray result (`unit_out_valid` in IDLE, or when `ret_cnt == len`): no write, and `err` is set. `err` is cleared only by reset.
- Counter widths: 11 bits, so that a length of 1024 is representable. Address sums truncate to 10 bits, so wrap-around past 1023 is legal and continues at 0.
- Reset mid-operation: FIFO flushed, FSM to IDLE, in-flight results dropped.

## Timing
- Reset values: `cmd_ready = 1`; `rd_addr = 0`; `unit_in_valid = 0`; `unit_opmode = 0`; `wr_addr = 0`; `wr_data = 0`; `wr_we = 0`; `busy = 0`; `done = 0`; `err = 0`.
- Command accepted at cycle T:
  - IDLE pop at T+1.
  - First `rd_addr` at T+2.
  - First `unit_in_valid` at T+2+`RD_LAT`.
- One address is issued per cycle; there is no backpressure from the unit.
- A write appears 1 cycle after its `unit_out_valid`.
- `done` is asserted in the cycle after the last write is registered.
- Back-to-back commands: the next IDLE pop happens the cycle after `done`. Minimum gap is 2 + unit latency.

## Configuration
- `UNIT_SEQ_PERF_EN` defined: adds two outputs.
  - `perf_busy` out 32: counts cycles with `busy = 1`.
  - `perf_cmds` out 16: counts `done` pulses.
  - Both reset to 0 and wrap silently.
- Undefined: those ports and their counters do not exist. All other behaviour is identical.

## Structure
- Shared package `unit_pkg`:
  - FSM state enum.
  - Command struct `{opmode[7:0], src[9:0], dst[9:0], len[9:0]}` (38 bits).
  - Constants `BRAM_AW = 10`, `VEC_W = 256`, `BRAM_W = 288`.
- One sub-module, `cmd_fifo`: synchronous FIFO of command structs with registered full/empty flags. The FSM, counters and writeback live in the top module.

## Test plan
- Single command (opmode `8'h00`, src 0, dst 100, len 4), unit model with 3-cycle latency:
  - `rd_addr` 0..3 on consecutive cycles, with `unit_in_valid` `RD_LAT` later.
  - Writes to 100..103 with `wr_we = '1` and `wr_data[287:256] = 0`.
  - Exactly one `done` pulse.
- Two commands queued back-to-back with opmodes `8'h00` then `8'h80`: `unit_opmode` changes only after the first command's 4th write, and never while a vector is in flight.
- Wrap-around with src 1022, dst 1023, len 3: reads 1022, 1023, 0; writes 1023, 0, 1.
- `cmd_len = 0`: 1024 reads and 1024 writes, then `done`.
- FIFO full:
  - Push 5 commands with `CMD_DEPTH = 4` while the first is busy: `cmd_ready` drops after 4 queued.
  - The 5th command is accepted in the same cycle a pop frees a slot.
- Inject `unit_out_valid` in IDLE: no write occurs and `err` goes to 1 and stays. Asserting `rst` low mid-ISSUE flushes everything and all outputs take their reset values asynchronously.

Source files
------------

// File: rtl/unit_pkg.sv
// Shared types and constants for the compute-unit command sequencer.
// Holds the FSM state encoding, the command descriptor layout and the BRAM geometry.
package unit_pkg;

    localparam int BRAM_AW = 10;
    localparam int VEC_W   = 256;
    localparam int BRAM_W  = 288;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [7:0]         opmode;
        logic [BRAM_AW-1:0] src;
        logic [BRAM_AW-1:0] dst;
        logic [BRAM_AW-1:0] len;
    } cmd_t;

    // A length field of zero stands for a full 1024-vector sweep.
    function automatic logic [BRAM_AW:0] len_eff(input logic [BRAM_AW-1:0] len);
        return {len == '0, len};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// A simultaneous push and pop are both honoured; pushes while full are ignored.
module cmd_fifo
    import unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == (AW+1)'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/unit_cmd_sequencer.sv
// Command-driven operand sweep and result writeback for the compute unit.
// Optional performance counters are built when UNIT_SEQ_PERF_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for a queued command; pops and latches it
// ST_ISSUE | one operand read address per cycle, len addresses total
// ST_DRAIN | waiting for the remaining results; done when all written
module unit_cmd_sequencer
    import unit_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_opmode,
    input  logic [BRAM_AW-1:0] cmd_src,
    input  logic [BRAM_AW-1:0] cmd_dst,
    input  logic [BRAM_AW-1:0] cmd_len,
    output logic [BRAM_AW-1:0] rd_addr,
    output logic               unit_in_valid,
    output logic [7:0]         unit_opmode,
    input  logic [VEC_W-1:0]   unit_out,
    input  logic               unit_out_valid,
    output logic [BRAM_AW-1:0] wr_addr,
    output logic [BRAM_W-1:0]  wr_data,
    output logic [35:0]        wr_we,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef UNIT_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_busy,
    output logic [15:0]        perf_cmds
`endif
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    cmd_t              cmd_in;
    cmd_t              head;
    cmd_t              cur;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [BRAM_AW:0]  issue_cnt;
    logic [BRAM_AW:0]  ret_cnt;
    logic [BRAM_AW:0]  len_e;
    logic [RD_LAT-1:0] vld_pipe;
    logic              wr_ok;
    logic              stray;

    assign cmd_in = '{opmode: cmd_opmode, src: cmd_src, dst: cmd_dst, len: cmd_len};

    cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready     = !fifo_full;
    assign busy          = (state != ST_IDLE) || !fifo_empty;
    assign len_e         = len_eff(cur.len);
    assign rd_addr       = cur.src + issue_cnt[BRAM_AW-1:0];
    assign unit_in_valid = vld_pipe[RD_LAT-1];
    assign wr_ok         = unit_out_valid && (state != ST_IDLE) && (ret_cnt != len_e);
    assign stray         = unit_out_valid && !wr_ok;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_cnt + 11'd1 == len_e) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (ret_cnt == len_e) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Opmode only reloads on a pop, and pops only happen once every result is back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= '0;
            unit_opmode <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            vld_pipe    <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_we       <= '0;
            err         <= 1'b0;
        end else begin
            vld_pipe[0] <= (state == ST_ISSUE);
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (pop) begin
                cur         <= head;
                unit_opmode <= head.opmode;
                issue_cnt   <= '0;
                ret_cnt     <= '0;
            end else begin
                if (state == ST_ISSUE) issue_cnt <= issue_cnt + 11'd1;
                if (wr_ok)             ret_cnt   <= ret_cnt + 11'd1;
            end
            wr_we <= '0;
            if (wr_ok) begin
                wr_addr <= cur.dst + ret_cnt[BRAM_AW-1:0];
                wr_data <= {32'b0, unit_out};
                wr_we   <= '1;
            end
            if (stray) err <= 1'b1;
        end
    end

`ifdef UNIT_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy <= '0;
            perf_cmds <= '0;
        end else begin
            if (busy) perf_busy <= perf_busy + 32'd1;
            if (done) perf_cmds <= perf_cmds + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unit_cmd_sequencer.sv
// Directed bench for unit_cmd_sequencer with a 3-cycle unit model.
// A monitor logs issued reads, writes, done pulses and opmode changes for later checks.
module tb_unit_cmd_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [7:0]   cmd_opmode = '0;
    logic [9:0]   cmd_src = '0;
    logic [9:0]   cmd_dst = '0;
    logic [9:0]   cmd_len = '0;
    logic [9:0]   rd_addr;
    logic         unit_in_valid;
    logic [7:0]   unit_opmode;
    logic [255:0] unit_out = '0;
    logic         unit_out_valid = 1'b0;
    logic [9:0]   wr_addr;
    logic [287:0] wr_data;
    logic [35:0]  wr_we;
    logic         busy;
    logic         done;
    logic         err;

    unit_cmd_sequencer #(.CMD_DEPTH(4), .RD_LAT(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_opmode     (cmd_opmode),
        .cmd_src        (cmd_src),
        .cmd_dst        (cmd_dst),
        .cmd_len        (cmd_len),
        .rd_addr        (rd_addr),
        .unit_in_valid  (unit_in_valid),
        .unit_opmode    (unit_opmode),
        .unit_out       (unit_out),
        .unit_out_valid (unit_out_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_we          (wr_we),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // monitor state
    int         rd_q[$];
    int         wr_q[$];
    int         done_q[$];
    int         n_iv, n_wr, data_err, we_err, opm_err, done_cnt;
    int         first_iv_cyc, last_iv_cyc, first_wr_cyc, last_wr_cyc, opm_chg_cyc;
    logic [9:0] prev_rd = '0;
    logic [7:0] prev_opm = '0;

    // unit model state
    logic [2:0]  v = '0;
    logic [31:0] d [3] = '{default: '0};
    int          seq = 0;
    logic        inj = 1'b0;

    task automatic clear_stats();
        rd_q.delete(); wr_q.delete(); done_q.delete();
        n_iv = 0; n_wr = 0; data_err = 0; we_err = 0; opm_err = 0; done_cnt = 0;
        first_iv_cyc = -1; last_iv_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
        opm_chg_cyc = -1; seq = 0;
    endtask

    initial begin
        clear_stats();
        forever begin
            @(posedge clk); #1;
            if (unit_opmode != prev_opm) begin
                if (n_iv - n_wr > 0) opm_err++;
                if (opm_chg_cyc < 0) opm_chg_cyc = cyc;
            end
            if (unit_in_valid) begin
                rd_q.push_back(int'(prev_rd));
                if (first_iv_cyc < 0) first_iv_cyc = cyc;
                last_iv_cyc = cyc;
                n_iv++;
            end
            if (wr_we != '0) begin
                if (wr_we != '1) we_err++;
                if (wr_data[287:256] != 32'h0 || wr_data[31:0] != (32'hA500_0000 | n_wr)
                    || wr_data[255:224] != (32'hA500_0000 | n_wr)) data_err++;
                wr_q.push_back(int'(wr_addr));
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                n_wr++;
            end
            if (done) begin
                done_cnt++;
                done_q.push_back(cyc);
            end
            prev_rd  = rd_addr;
            prev_opm = unit_opmode;
        end
    end

    // 3-cycle unit: result for an in_valid seen in cycle c is presented in cycle c+3
    initial forever begin
        @(posedge clk); #1;
        if (!rst) begin
            v = '0;
            unit_out_valid = 1'b0;
        end else begin
            unit_out_valid = v[2] | inj;
            unit_out = {8{d[2]}};
            v = {v[1:0], unit_in_valid};
            d[2] = d[1];
            d[1] = d[0];
            d[0] = 32'hA500_0000 | seq;
            if (unit_in_valid) seq++;
        end
    end

    task automatic push(input logic [7:0] o, input int s, input int ds, input int l, output int t);
        t = -1;
        @(negedge clk);
        cmd_opmode = o; cmd_src = s[9:0]; cmd_dst = ds[9:0]; cmd_len = l[9:0];
        cmd_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (cmd_ready) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("push_accepted", t >= 0, 1);
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_cnt < n; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        chk("done_count", done_cnt, n);
    endtask

    int t0, t1, t2, nw;

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_in_valid", unit_in_valid, 0);
        chk("rst_opmode", unit_opmode, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data_zero", wr_data == '0, 1);
        chk("rst_wr_we", wr_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // single command with latency checks
        clear_stats();
        push(8'h00, 0, 100, 4, t0);
        wait_done(1, 100);
        repeat (10) @(posedge clk);
        #2;
        chk("t1_done_once", done_cnt, 1);
        chk("t1_first_iv", first_iv_cyc, t0 + 3);
        chk("t1_iv_consecutive", last_iv_cyc, t0 + 6);
        chk("t1_rd_count", rd_q.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_rd%0d", i), rd_q[i], i);
        chk("t1_wr_count", wr_q.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_wr%0d", i), wr_q[i], 100 + i);
        chk("t1_first_wr", first_wr_cyc, t0 + 7);
        chk("t1_done_cyc", done_q[0], last_wr_cyc);
        chk("t1_we_err", we_err, 0);
        chk("t1_data_err", data_err, 0);
        chk("t1_busy_after", busy, 0);

        // back-to-back commands, opmode switch
        clear_stats();
        push(8'h00, 0, 200, 4, t0);
        push(8'h80, 10, 300, 4, t1);
        chk("t2_b2b_accept", t1, t0 + 1);
        wait_done(2, 200);
        chk("t2_rd4", rd_q[4], 10);
        chk("t2_rd7", rd_q[7], 13);
        chk("t2_wr3", wr_q[3], 203);
        chk("t2_wr4", wr_q[4], 300);
        chk("t2_opm_inflight", opm_err, 0);
        chk("t2_opm_chg_cyc", opm_chg_cyc, done_q[0] + 2);
        chk("t2_opmode", unit_opmode, 8'h80);
        chk("t2_data_err", data_err, 0);

        // address wrap-around
        clear_stats();
        push(8'h11, 1022, 1023, 3, t0);
        wait_done(1, 100);
        chk("t3_rd0", rd_q[0], 1022);
        chk("t3_rd1", rd_q[1], 1023);
        chk("t3_rd2", rd_q[2], 0);
        chk("t3_wr0", wr_q[0], 1023);
        chk("t3_wr1", wr_q[1], 0);
        chk("t3_wr2", wr_q[2], 1);

        // length 0 means 1024
        clear_stats();
        push(8'h22, 5, 7, 0, t0);
        wait_done(1, 1300);
        chk("t4_rd_count", rd_q.size(), 1024);
        chk("t4_wr_count", wr_q.size(), 1024);
        chk("t4_rd0", rd_q[0], 5);
        chk("t4_rd1018", rd_q[1018], 1023);
        chk("t4_rd1019", rd_q[1019], 0);
        chk("t4_rd_last", rd_q[1023], 4);
        chk("t4_wr1017", wr_q[1017], 0);
        chk("t4_wr_last", wr_q[1023], 6);
        chk("t4_data_err", data_err, 0);

        // FIFO full: one running plus four queued, sixth waits for a pop
        clear_stats();
        push(8'h33, 0, 0, 4, t0);
        for (int i = 1; i < 5; i++) push(8'h33, 16 * i, 16 * i, 4, t1);
        @(negedge clk);
        chk("t5_full_ready", cmd_ready, 0);
        push(8'h33, 80, 80, 4, t2);
        chk("t5_accept_after_pop", t2, done_q[0] + 2);
        wait_done(6, 300);
        chk("t5_rd_count", rd_q.size(), 24);
        for (int i = 0; i < 6; i++) chk($sformatf("t5_cmd%0d_src", i), rd_q[4 * i], 16 * i);
        chk("t5_wr_last", wr_q[23], 83);

        // stray result in IDLE
        chk("t6_err_clean", err, 0);
        nw = n_wr;
        @(negedge clk); inj = 1'b1;
        @(negedge clk); inj = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("t6_no_write", n_wr, nw);
        chk("t6_err_set", err, 1);
        repeat (10) @(posedge clk);
        #2;
        chk("t6_err_sticky", err, 1);

        // asynchronous reset mid-ISSUE with commands still queued
        clear_stats();
        push(8'h3C, 0, 500, 0, t0);
        push(8'h44, 0, 0, 4, t1);
        push(8'h55, 0, 0, 4, t1);
        for (int i = 0; i < 100 && n_iv < 5; i++) @(posedge clk);
        @(posedge clk); #2;
        chk("t7_opm_before", unit_opmode, 8'h3C);
        rst = 1'b0;
        #1;
        chk("t7_cmd_ready", cmd_ready, 1);
        chk("t7_rd_addr", rd_addr, 0);
        chk("t7_in_valid", unit_in_valid, 0);
        chk("t7_opmode", unit_opmode, 0);
        chk("t7_wr_addr", wr_addr, 0);
        chk("t7_wr_data_zero", wr_data == '0, 1);
        chk("t7_wr_we", wr_we, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        clear_stats();
        repeat (20) @(posedge clk);
        #2;
        chk("t7_flushed_no_issue", n_iv, 0);
        chk("t7_flushed_no_write", n_wr, 0);
        chk("t7_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
